// File: rtl/kv_vector_sram_if.sv
// kv_vector_sram_if: write/read handshake bundle for the K/V vector store.
// master: controller + compute side (drives clear, wr_vld/wr_vector, rd_rdy).
// slave : the store (drives wr_rdy, rd_* outputs, pass_index, loaded, done).
// With KV_SRAM_PARITY_EN defined, adds parity_inject (master->slave) and
// parity_err (slave->master).
interface kv_vector_sram_if #(
    parameter int DEPTH      = 64,
    parameter int VEC_W      = 512,
    parameter int NUM_PASSES = 64
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PASS_W = $clog2(NUM_PASSES + 1);

    logic              clear;
    logic              wr_vld;
    logic              wr_rdy;
    logic [VEC_W-1:0]  wr_vector;
    logic              rd_vld;
    logic              rd_rdy;
    logic [VEC_W-1:0]  rd_vector;
    logic [IDX_W-1:0]  rd_index;
    logic              rd_last;
    logic [PASS_W-1:0] pass_index;
    logic              loaded;
    logic              done;
`ifdef KV_SRAM_PARITY_EN
    logic              parity_inject;
    logic              parity_err;
`endif

    modport master (
`ifdef KV_SRAM_PARITY_EN
        output parity_inject,
        input  parity_err,
`endif
        output clear, wr_vld, wr_vector, rd_rdy,
        input  wr_rdy, rd_vld, rd_vector, rd_index, rd_last, pass_index, loaded, done
    );

    modport slave (
`ifdef KV_SRAM_PARITY_EN
        input  parity_inject,
        output parity_err,
`endif
        input  clear, wr_vld, wr_vector, rd_rdy,
        output wr_rdy, rd_vld, rd_vector, rd_index, rd_last, pass_index, loaded, done
    );
endinterface

// File: rtl/kv_vector_sram.sv
// kv_vector_sram: fills DEPTH vectors over a valid/ready write port, then
// replays them in order NUM_PASSES times over a valid/ready read port.
// Ports: clk, rst (async, active-high), bus (kv_vector_sram_if.slave).
// Optional: KV_SRAM_PARITY_EN adds a per-row even-parity bit, parity_inject
// and the sticky parity_err flag.
module kv_vector_sram #(
    parameter int DEPTH      = 64,
    parameter int VEC_W      = 512,
    parameter int NUM_PASSES = 64
) (
    input  logic             clk,
    input  logic             rst,
    kv_vector_sram_if.slave  bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PASS_W = $clog2(NUM_PASSES + 1);
    localparam logic [IDX_W-1:0]  LAST_ROW = IDX_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] PASS_END = PASS_W'(NUM_PASSES);

    typedef enum logic [1:0] {FILL, STREAM, DONE} state_t;

    state_t            state_q;
    logic [VEC_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d, rd_index_q;
    logic [PASS_W-1:0] pass_q, pass_d, pass_index_q;
    logic [VEC_W-1:0]  rd_vector_q;
    logic              wr_rdy_q, rd_vld_q, rd_last_q, loaded_q, done_q;
    logic              wr_fire, rd_load, rd_fire;

    assign wr_fire  = state_q == FILL && bus.wr_vld && !bus.clear;
    assign rd_fire  = rd_vld_q && bus.rd_rdy;
    // Output register refills when empty or draining, until every sweep is fetched.
    assign rd_load  = state_q == STREAM && (!rd_vld_q || bus.rd_rdy) && pass_q != PASS_END;
    assign rd_ptr_d = rd_ptr_q + 1'b1;
    assign pass_d   = rd_ptr_q == LAST_ROW ? pass_q + 1'b1 : pass_q;

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= bus.wr_vector;
    end

`ifdef KV_SRAM_PARITY_EN
    logic mem_par [DEPTH];
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (wr_fire) mem_par[wr_ptr_q] <= ^bus.wr_vector ^ bus.parity_inject;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err_q <= 1'b0;
        else if (bus.clear) parity_err_q <= 1'b0;
        else if (rd_load && (^mem[rd_ptr_q]) != mem_par[rd_ptr_q]) parity_err_q <= 1'b1;
    end

    assign bus.parity_err = parity_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pass_q       <= '0;
            wr_rdy_q     <= 1'b1;
            rd_vld_q     <= 1'b0;
            rd_vector_q  <= '0;
            rd_index_q   <= '0;
            rd_last_q    <= 1'b0;
            pass_index_q <= '0;
            loaded_q     <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.clear) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pass_q       <= '0;
            wr_rdy_q     <= 1'b1;
            rd_vld_q     <= 1'b0;
            rd_index_q   <= '0;
            rd_last_q    <= 1'b0;
            pass_index_q <= '0;
            loaded_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                FILL: if (bus.wr_vld) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ROW) begin
                        state_q  <= STREAM;
                        loaded_q <= 1'b1;
                        wr_rdy_q <= 1'b0;
                    end
                end
                STREAM: if (rd_load) begin
                    rd_vld_q     <= 1'b1;
                    rd_vector_q  <= mem[rd_ptr_q];
                    rd_index_q   <= rd_ptr_q;
                    rd_last_q    <= rd_ptr_q == LAST_ROW;
                    pass_index_q <= pass_q;
                    rd_ptr_q     <= rd_ptr_d;
                    pass_q       <= pass_d;
                end else if (rd_fire) begin
                    // Final accept with nothing left to fetch.
                    rd_vld_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: ;
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.wr_rdy     = wr_rdy_q;
    assign bus.rd_vld     = rd_vld_q;
    assign bus.rd_vector  = rd_vector_q;
    assign bus.rd_index   = rd_index_q;
    assign bus.rd_last    = rd_last_q;
    assign bus.pass_index = pass_index_q;
    assign bus.loaded     = loaded_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_kv_vector_sram.sv
// tb_kv_vector_sram: directed bench with a queue-based reference model for kv_vector_sram.
module tb_kv_vector_sram;
    localparam int DEPTH = 4;
    localparam int VEC_W = 32;
    localparam int NP    = 2;

    typedef struct {
        logic [VEC_W-1:0] vec;
        int               idx;
        int               pass;
    } rd_t;

    logic clk = 1'b0;
    logic rst;

    kv_vector_sram_if #(.DEPTH(DEPTH), .VEC_W(VEC_W), .NUM_PASSES(NP)) bus ();
    kv_vector_sram #(.DEPTH(DEPTH), .VEC_W(VEC_W), .NUM_PASSES(NP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int               n_chk = 0;
    int               n_fail = 0;
    rd_t              expq[$];
    logic [VEC_W-1:0] mdl_mem [DEPTH];
    bit               bad [DEPTH];
    logic [VEC_W-1:0] acc_log[$];
    int               wcount, accepted, age;
    bit               perr, ld, ev;
    bit               rdy_mode = 0;
    bit               rdy_level = 0;
    bit               inj = 0;
    int               cyc = 0;
    rd_t              e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wcount = 0;
        accepted = 0;
        age = 0;
        perr = 0;
        expq.delete();
        for (int i = 0; i < DEPTH; i++) bad[i] = 0;
    endtask

    // Reference: after DEPTH writes, the reads are every row in order, NP times.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                ld = wcount == DEPTH;
                ev = ld && age >= 1 && expq.size() > 0;
                chk("wr_rdy", bus.wr_rdy, !ld);
                chk("loaded", bus.loaded, ld);
                chk("done", bus.done, ld && accepted == NP * DEPTH);
                chk("rd_vld", bus.rd_vld, ev);
                if (ev) begin
                    chk("rd_vector", bus.rd_vector, expq[0].vec);
                    chk("rd_index", bus.rd_index, expq[0].idx);
                    chk("rd_last", bus.rd_last, expq[0].idx == DEPTH - 1);
                    chk("pass_index", bus.pass_index, expq[0].pass);
                end
                if (!ld) begin
                    chk("fill_rd_index", bus.rd_index, 0);
                    chk("fill_pass_index", bus.pass_index, 0);
                    chk("fill_rd_last", bus.rd_last, 0);
                end
`ifdef KV_SRAM_PARITY_EN
                if (ev && bad[expq[0].idx]) perr = 1;
                chk("parity_err", bus.parity_err, perr);
`endif
                if (bus.clear) begin
                    model_reset();
                end else begin
                    if (ld) age++;
                    if (ev && bus.rd_rdy) begin
                        acc_log.push_back(expq[0].vec);
                        void'(expq.pop_front());
                        accepted++;
                    end
                    if (!ld && bus.wr_vld) begin
                        mdl_mem[wcount] = bus.wr_vector;
                        bad[wcount] = inj;
                        wcount++;
                        if (wcount == DEPTH) begin
                            age = 0;
                            for (int p = 0; p < NP; p++)
                                for (int i = 0; i < DEPTH; i++) begin
                                    e.vec = mdl_mem[i];
                                    e.idx = i;
                                    e.pass = p;
                                    expq.push_back(e);
                                end
                        end
                    end
                end
            end
        end
    end

    initial begin
        bus.rd_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_rdy = rdy_mode ? (cyc % 3 == 0) : rdy_level;
            if (rdy_mode) cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [VEC_W-1:0] v, input int gap, input bit inject);
        bus.wr_vld = 1'b1;
        bus.wr_vector = v;
        inj = inject;
`ifdef KV_SRAM_PARITY_EN
        bus.parity_inject = inject;
`endif
        step();
        bus.wr_vld = 1'b0;
        inj = 0;
`ifdef KV_SRAM_PARITY_EN
        bus.parity_inject = 1'b0;
`endif
        repeat (gap) step();
    endtask

    task automatic fill(input logic [VEC_W-1:0] base, input int gap, input int bad_row);
        for (int i = 0; i < DEPTH; i++) write(base * (i + 1), gap, i == bad_row);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !bus.done; i++) step();
        chk("done_timeout", bus.done, 1);
    endtask

    task automatic chk_log(input logic [VEC_W-1:0] base);
        chk("log_size", acc_log.size(), NP * DEPTH);
        for (int i = 0; i < acc_log.size() && i < NP * DEPTH; i++)
            chk("log_vec", acc_log[i], base * ((i % DEPTH) + 1));
    endtask

    initial begin
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.wr_vld = 1'b0;
        bus.wr_vector = '0;
`ifdef KV_SRAM_PARITY_EN
        bus.parity_inject = 1'b0;
`endif
        repeat (2) step();
        chk("rst_wr_rdy", bus.wr_rdy, 1);
        chk("rst_rd_vld", bus.rd_vld, 0);
        chk("rst_rd_vector", bus.rd_vector, 0);
        chk("rst_loaded", bus.loaded, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        step();

        // Back-to-back fill, always-ready consumer.
        rdy_level = 1;
        acc_log.delete();
        fill(32'h11, 0, -1);
        chk("t1_wr_rdy_after_last", bus.wr_rdy, 0);
        chk("t1_loaded", bus.loaded, 1);
        chk("t1_rd_vld_early", bus.rd_vld, 0);
        step();
        chk("t1_rd_vld_rise", bus.rd_vld, 1);
        chk("t1_first_vec", bus.rd_vector, 32'h11);
        wait_done();
        chk_log(32'h11);
        repeat (3) step();
        chk("t1_done_hold", bus.done, 1);

        // Stalling consumer with a 1,0,0 ready pattern.
        do_clear();
        acc_log.delete();
        cyc = 0;
        rdy_mode = 1;
        fill(32'h11, 0, -1);
        wait_done();
        chk_log(32'h11);
        rdy_mode = 0;

        // Sparse writes, plus writes attempted while streaming.
        do_clear();
        acc_log.delete();
        fill(32'h11, 2, -1);
        chk("t3_loaded", bus.loaded, 1);
        write(32'hDEAD, 0, 0);
        write(32'hBEEF, 0, 0);
        wait_done();
        chk_log(32'h11);

        // Clear on the cycle of the third accept, then refill.
        do_clear();
        acc_log.delete();
        fill(32'h11, 0, -1);
        for (int i = 0; i < 50 && accepted < 2; i++) step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("t4_wr_rdy", bus.wr_rdy, 1);
        chk("t4_pass_index", bus.pass_index, 0);
        chk("t4_done", bus.done, 0);
        chk("t4_rd_vld", bus.rd_vld, 0);
        chk("t4_rd_vector_held", bus.rd_vector, 32'h33);
        chk("t4_accepts_before_clear", acc_log.size(), 2);
        acc_log.delete();
        fill(32'h0A1, 0, -1);
        wait_done();
        chk_log(32'h0A1);

        // Asynchronous reset mid-stream.
        do_clear();
        fill(32'h11, 0, -1);
        for (int i = 0; i < 50 && accepted < 3; i++) step();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rd_vld", bus.rd_vld, 0);
        chk("t5_loaded", bus.loaded, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_wr_rdy", bus.wr_rdy, 1);
        step();
        rst = 1'b0;
        step();

`ifdef KV_SRAM_PARITY_EN
        // Corrupted parity on row 2.
        acc_log.delete();
        fill(32'h11, 0, 2);
        step();
        chk("t6_no_err_row0", bus.parity_err, 0);
        wait_done();
        chk("t6_err_sticky", bus.parity_err, 1);
        do_clear();
        chk("t6_err_cleared", bus.parity_err, 0);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/kv_vector_sram.md
Name: kv_vector_sram

Overview:
- Vector store between the memory controller's load phases and the attention datapath.
- One instance holds K and one holds V.
- Accepts DEPTH vectors from the controller over a valid/ready write port, then replays them in order NUM_PASSES times to the compute pipeline over a valid/ready read port. The compute pipeline rereads K/V once per Q vector.
- Its write-side ready is the controller's K/V SRAM ready input.

Parameters:
- DEPTH, 64, vectors stored; equals sequence length; power of two, >= 2.
- VEC_W, 512, bits per vector (64 x int8).
- NUM_PASSES, 64, full read sweeps before done; >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clear  in  1  synchronous restart to FILL
- wr_vld  in  1  write vector valid (controller K/V valid)
- wr_rdy  out  1  ready to accept a write
- wr_vector  in  VEC_W  vector from controller
- rd_vld  out  1  read vector valid
- rd_rdy  in  1  consumer ready
- rd_vector  out  VEC_W  registered output vector
- rd_index  out  clog2(DEPTH)  row index of rd_vector
- rd_last  out  1  rd_vector is row DEPTH-1
- pass_index  out  clog2(NUM_PASSES+1)  current sweep number
- loaded  out  1  all DEPTH rows written
- done  out  1  all passes consumed

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=FILL, wr_ptr=0, rd_ptr=0, pass=0, wr_rdy=1, rd_vld=0, rd_vector=0, rd_index=0, rd_last=0, pass_index=0, loaded=0, done=0. Array contents are not reset.
- Handshake: a transfer occurs when vld && rdy on a rising edge. Once raised, rd_vld holds with stable rd_vector/rd_index until accepted. wr_vld with wr_rdy=0 is ignored (no state change).
- FILL state:
  - wr_rdy=1.
  - Each write stores wr_vector at wr_ptr; wr_ptr increments.
  - Write at wr_ptr=DEPTH-1 moves to STREAM next cycle, with loaded=1 and wr_rdy=0 from that cycle on.
- STREAM state:
  - One-entry output register, loaded from array[rd_ptr] when empty or when being accepted this cycle; rd_ptr advances on each load.
  - First rd_vld rises the cycle after entering STREAM, i.e. 2 cycles after the last write.
  - Back-to-back accepts sustain one vector per cycle with no bubbles.
- Wrap: when rd_ptr passes DEPTH-1 it wraps to 0 and pass increments.
  - pass_index reflects the sweep of the vector currently in rd_vector.
  - rd_last=1 iff rd_index==DEPTH-1.
- Exit to DONE:
  - After NUM_PASSES*DEPTH accepts, the register is not reloaded.
  - On the cycle after the final accept: rd_vld=0, done=1, state=DONE.
- DONE state: holds until clear or rst; wr_rdy=0; loaded stays 1.
- clear:
  - Takes effect on the next edge from any state and has priority over simultaneous handshakes; that cycle's transfer is dropped.
  - Returns all registers to reset values except rd_vector (held) and array contents.
- Writes during STREAM/DONE are impossible (wr_rdy=0).
- rd_rdy during FILL has no effect.
- rst mid-operation: immediate return to reset values regardless of state.
- Arithmetic widths: pointers are clog2(DEPTH) bits with natural wrap. pass counts to NUM_PASSES inclusive; its width must not overflow.

Optional Feature:
- KV_SRAM_PARITY_EN defined:
  - Each row stores an extra even-parity bit computed over wr_vector on write.
  - On each output-register load, parity is recomputed. On mismatch, the sticky output parity_err (1 bit, reset 0, cleared by clear) sets the cycle that rd_vector updates.
  - Adds input parity_inject (1 bit). When high during a write, the stored parity bit is inverted.
- Undefined: no parity storage, no parity_err/parity_inject ports; behaviour otherwise identical.

Test Plan:
- DEPTH=4, NUM_PASSES=2; write 0x11,0x22,0x33,0x44 back-to-back with rd_rdy=1 -> wr_rdy low the cycle after the 4th write; rd_vld rises 2 cycles after the 4th write; read order 11,22,33,44,11,22,33,44 on consecutive cycles; rd_last on 44; pass_index 0 then 1; done=1 the cycle after the 8th accept.
- Same fill, rd_rdy toggled 1,0,0,1,... -> rd_vector/rd_index stable through stalls; no vector lost or repeated; 8 accepts total.
- wr_vld gaps (1 vector every 3 cycles) -> loaded only after the 4th write; rd_vld stays 0 throughout FILL.
- Assert clear on the cycle of the 3rd read accept -> that accept dropped; next cycle state=FILL, wr_rdy=1, pass_index=0, done=0; refill with new data reads back the new data.
- Assert rst asynchronously mid-STREAM (between edges) -> rd_vld, loaded, done drop immediately; wr_rdy=1.
- KV_SRAM_PARITY_EN: parity_inject on row 2 -> parity_err rises when row 2 is presented; stays 1 through the remaining reads until clear.
